// File: rtl/nts_api_pkg.sv
// Shared definitions for the NTS external API bus: widths, latency limit and
// the arbiter FSM encoding.
package nts_api_pkg;

  localparam int API_AW           = 12;
  localparam int API_DW           = 32;
  localparam int READ_LATENCY_MAX = 7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } api_state_t;

endpackage

// File: rtl/nts_api_arbiter.sv
// Two-master round-robin arbiter for the NTS API bus: one transaction at a
// time, single-cycle chip select, read data captured after a fixed latency.
module nts_api_arbiter
  import nts_api_pkg::*;
#(
  parameter int READ_LATENCY = 1
) (
  input  logic              i_clk,
  input  logic              i_areset,
  input  logic              i_m0_req,
  input  logic              i_m0_we,
  input  logic [API_AW-1:0] i_m0_address,
  input  logic [API_DW-1:0] i_m0_write_data,
  output logic              o_m0_ack,
  output logic [API_DW-1:0] o_m0_read_data,
  input  logic              i_m1_req,
  input  logic              i_m1_we,
  input  logic [API_AW-1:0] i_m1_address,
  input  logic [API_DW-1:0] i_m1_write_data,
  output logic              o_m1_ack,
  output logic [API_DW-1:0] o_m1_read_data,
  output logic              o_api_cs,
  output logic              o_api_we,
  output logic [API_AW-1:0] o_api_address,
  output logic [API_DW-1:0] o_api_write_data,
  input  logic [API_DW-1:0] i_api_read_data,
  output logic              o_busy,
  output logic [1:0]        o_grant
);

  if (READ_LATENCY < 0 || READ_LATENCY > READ_LATENCY_MAX) begin : g_bad_latency
    $error("nts_api_arbiter: READ_LATENCY out of range");
  end

  localparam logic [2:0] WAIT_LOAD = (READ_LATENCY > 0) ? 3'(READ_LATENCY - 1) : 3'd0;

  // Handshake: a master raises req with we/address/write_data and holds them
  // until it sees its one-cycle ack, then drops req the following cycle. Fields
  // are latched at grant; a req still high in IDLE starts a new transaction.

  api_state_t state, state_next;
  logic       last_grant;
  logic [2:0] wait_cnt;
  logic       grant_now;
  logic       pick_m1;
  logic       capture;

  always_comb begin
    state_next = state;
    grant_now  = 1'b0;
    pick_m1    = 1'b0;
    capture    = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (i_m0_req || i_m1_req) begin
          grant_now  = 1'b1;
          // On contention the master that did not win last time goes next.
          pick_m1    = i_m1_req && (!i_m0_req || !last_grant);
          state_next = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (o_api_we) begin
          state_next = ST_DONE;
        end else if (READ_LATENCY == 0) begin
          capture    = 1'b1;
          state_next = ST_DONE;
        end else begin
          state_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (wait_cnt == 3'd0) begin
          capture    = 1'b1;
          state_next = ST_DONE;
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_areset) begin
      state            <= ST_IDLE;
      last_grant       <= 1'b1;
      wait_cnt         <= 3'd0;
      o_api_cs         <= 1'b0;
      o_api_we         <= 1'b0;
      o_api_address    <= '0;
      o_api_write_data <= '0;
      o_m0_ack         <= 1'b0;
      o_m1_ack         <= 1'b0;
      o_m0_read_data   <= '0;
      o_m1_read_data   <= '0;
      o_busy           <= 1'b0;
      o_grant          <= 2'b00;
    end else begin
      state    <= state_next;
      o_api_cs <= grant_now;
      o_busy   <= (state_next != ST_IDLE);
      o_m0_ack <= (state_next == ST_DONE) && o_grant[0];
      o_m1_ack <= (state_next == ST_DONE) && o_grant[1];

      if (grant_now) begin
        o_grant          <= pick_m1 ? 2'b10 : 2'b01;
        last_grant       <= pick_m1;
        o_api_we         <= pick_m1 ? i_m1_we         : i_m0_we;
        o_api_address    <= pick_m1 ? i_m1_address    : i_m0_address;
        o_api_write_data <= pick_m1 ? i_m1_write_data : i_m0_write_data;
      end else if (state_next == ST_IDLE) begin
        o_grant <= 2'b00;
      end

      if (state == ST_ISSUE) begin
        wait_cnt <= WAIT_LOAD;
      end else if (state == ST_WAIT) begin
        wait_cnt <= wait_cnt - 3'd1;
      end

      if (capture && o_grant[0]) o_m0_read_data <= i_api_read_data;
      if (capture && o_grant[1]) o_m1_read_data <= i_api_read_data;
    end
  end

endmodule
